tick_sched_ctrl: RTL and testbench

//  Run/stop/single-step controller for the system timebase, on the clk_in domain.

---
 rtl/tick_sched_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tick_sched_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sched_ctrl.sv
// Run/stop/single-step timebase controller: a one-cycle tick every cur_div clk_in cycles and a clk_out that toggles on each tick.
// Optional feature macro TICK_CNT_EN adds a 16-bit tick counter output (tick_cnt).
module tick_sched_ctrl #(
    parameter int CNT_W   = 18,
    parameter int DEF_DIV = 5000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic [CNT_W-1:0] cur_div,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic [1:0]       o_dbg_state
`ifdef TICK_CNT_EN
    ,
    output logic [15:0]      tick_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend_vld;
    logic             r_tick;
    logic             r_clk_out;
    logic             r_busy;
    logic             r_div_ready;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cur_div_next;
    logic [CNT_W-1:0] w_pend_div_next;
    logic             w_pend_vld_next;
    logic             w_tick_next;
    logic             w_clk_out_next;
    logic             w_active;
    logic             w_wrap;
    logic             w_kill;
    logic             w_to_idle;
    logic             w_accept;
    logic [CNT_W-1:0] w_div_clamped;

    // Load port: a divisor transfers on any edge where div_valid && div_ready;
    // div_ready is a register (never a function of div_valid) and is low only
    // while a divisor waits in the pending register for the next period wrap.
    assign w_accept      = div_valid && r_div_ready;
    assign w_div_clamped = (div_in < MIN_DIV) ? MIN_DIV : div_in;
    assign w_active      = (r_state != ST_IDLE);
    assign w_wrap        = w_active && (r_cnt == (r_cur_div - CNT_W'(1)));
    assign w_kill        = stop && w_active;
    assign w_to_idle     = w_active && (w_next_state == ST_IDLE);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cur_div   <= DEF_DIV_W;
            r_pend_div  <= '0;
            r_pend_vld  <= 1'b0;
            r_tick      <= 1'b0;
            r_clk_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_div_ready <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_cur_div   <= w_cur_div_next;
            r_pend_div  <= w_pend_div_next;
            r_pend_vld  <= w_pend_vld_next;
            r_tick      <= w_tick_next;
            r_clk_out   <= w_clk_out_next;
            r_busy      <= (w_next_state != ST_IDLE);
            r_div_ready <= !w_pend_vld_next;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_cnt_next      = r_cnt;
        w_cur_div_next  = r_cur_div;
        w_pend_div_next = r_pend_div;
        w_pend_vld_next = r_pend_vld;
        w_tick_next     = 1'b0;
        w_clk_out_next  = r_clk_out;

        // stop also blocks start/step when idle, keeping stop > start > step
        if (stop) begin
            if (w_active) begin
                w_next_state = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next_state = ST_RUN;
                    end else if (step) begin
                        w_next_state = ST_STEP;
                    end
                end
                ST_RUN:  w_next_state = ST_RUN;
                ST_STEP: begin
                    if (r_tick) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end

        if ((w_next_state == ST_IDLE) || !w_active || w_wrap) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end

        w_tick_next = w_wrap && !w_kill;
        if (w_kill) begin
            w_clk_out_next = 1'b0;
        end else if (w_tick_next) begin
            w_clk_out_next = !r_clk_out;
        end

        // Idle loads land directly; loads while running wait for the wrap
        if (w_to_idle) begin
            if (w_accept) begin
                w_cur_div_next = w_div_clamped;
            end else if (r_pend_vld) begin
                w_cur_div_next = r_pend_div;
            end
            w_pend_vld_next = 1'b0;
        end else if (!w_active) begin
            if (w_accept) begin
                w_cur_div_next = w_div_clamped;
            end
        end else begin
            if (w_wrap && r_pend_vld) begin
                w_cur_div_next  = r_pend_div;
                w_pend_vld_next = 1'b0;
            end
            if (w_accept) begin
                w_pend_div_next = w_div_clamped;
                w_pend_vld_next = 1'b1;
            end
        end
    end

`ifdef TICK_CNT_EN
    logic [15:0] r_tick_cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= 16'd0;
        end else if ((r_state == ST_IDLE) && (w_next_state == ST_RUN)) begin
            r_tick_cnt <= 16'd0;
        end else if (w_tick_next) begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    assign tick_cnt = r_tick_cnt;
`endif

    assign div_ready   = r_div_ready;
    assign cur_div     = r_cur_div;
    assign tick        = r_tick;
    assign clk_out     = r_clk_out;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Directed self-checking bench for tick_sched_ctrl; tick times go through an expected-queue scoreboard.
// Build with TICK_CNT_EN defined to also check the optional tick counter.
`timescale 1ns/1ps
module tb_tick_sched_ctrl;

  logic        clk_in;
  logic        reset;
  logic        start;
  logic        stop;
  logic        step;
  logic [17:0] div_in;
  logic        div_valid;
  logic        div_ready;
  logic [17:0] cur_div;
  logic        tick;
  logic        clk_out;
  logic        busy;
  logic [1:0]  dbg_state;
`ifdef TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif

  int n_checks;
  int n_fail;
  int rel;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  tick_sched_ctrl dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .div_in      (div_in),
    .div_valid   (div_valid),
    .div_ready   (div_ready),
    .cur_div     (cur_div),
    .tick        (tick),
    .clk_out     (clk_out),
    .busy        (busy),
    .o_dbg_state (dbg_state)
`ifdef TICK_CNT_EN
    ,
    .tick_cnt    (tick_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc_step();
    @(posedge clk_in);
    #1;
    rel++;
    if (tick) obs_q.push_back(32'(rel));
  endtask

  task automatic run(input int n);
    repeat (n) cyc_step();
  endtask

  task automatic load_div(input logic [17:0] v);
    div_in    = v;
    div_valid = 1'b1;
    cyc_step();
    div_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc_step();
    start = 1'b0;
    rel = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc_step();
    step = 1'b0;
    rel = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc_step();
    stop = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
  endtask

  // scoreboard: tick times relative to the start/step edge
  task automatic compare_ticks(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_t%0d", tag, i), obs_q[i], exp_q[i]);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rel       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    step      = 1'b0;
    div_in    = 18'd0;
    div_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b0;

    check("rst_tick", 32'(tick), 0);
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_div_ready", 32'(div_ready), 1);
    check("rst_cur_div", 32'(cur_div), 5000);
    check("rst_state", 32'(dbg_state), 0);
`ifdef TICK_CNT_EN
    check("rst_tick_cnt", 32'(tick_cnt), 0);
`endif

    // default divisor, free run
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    check("t1_state", 32'(dbg_state), 1);
    run(4999);
    check("t1_tick_4999", 32'(tick), 0);
    check("t1_clk_4999", 32'(clk_out), 0);
    run(1);
    check("t1_tick_5000", 32'(tick), 1);
    check("t1_clk_5000", 32'(clk_out), 1);
    run(4999);
    check("t1_clk_9999", 32'(clk_out), 1);
    run(1);
    check("t1_clk_10000", 32'(clk_out), 0);
    run(5000);
    exp_q = '{32'd5000, 32'd10000, 32'd15000};
    compare_ticks("t1_ticks");
`ifdef TICK_CNT_EN
    check("t1_tick_cnt", 32'(tick_cnt), 3);
`endif
    pulse_stop();
    check("t1_stop_busy", 32'(busy), 0);
    check("t1_stop_clk", 32'(clk_out), 0);

    // divisor change while running waits for the wrap
    load_div(18'd10);
    check("t2_cur_div_10", 32'(cur_div), 10);
    pulse_start();
    run(3);
    load_div(18'd4);
    check("t2_ready_pend", 32'(div_ready), 0);
    check("t2_cur_div_old", 32'(cur_div), 10);
    run(5);
    check("t2_ready_9", 32'(div_ready), 0);
    run(1);
    check("t2_cur_div_new", 32'(cur_div), 4);
    check("t2_ready_back", 32'(div_ready), 1);
    run(8);
    exp_q = '{32'd10, 32'd14, 32'd18};
    compare_ticks("t2_ticks");
    pulse_stop();

    // single step, second step ignored
    load_div(18'd3);
    pulse_step();
    check("t3_busy", 32'(busy), 1);
    check("t3_state", 32'(dbg_state), 2);
    run(1);
    step = 1'b1;
    cyc_step();
    step = 1'b0;
    run(1);
    check("t3_tick", 32'(tick), 1);
    check("t3_busy_at_tick", 32'(busy), 1);
    run(1);
    check("t3_busy_after", 32'(busy), 0);
    check("t3_state_after", 32'(dbg_state), 0);
    run(6);
    exp_q = '{32'd3};
    compare_ticks("t3_ticks");

    apply_reset();

    // divisor clamp and minimum period
    load_div(18'd0);
    check("t4_clamp0", 32'(cur_div), 2);
    load_div(18'd9);
    check("t4_load9", 32'(cur_div), 9);
    load_div(18'd1);
    check("t4_clamp1", 32'(cur_div), 2);
    pulse_start();
    run(2);
    check("t4_clk_2", 32'(clk_out), 1);
    run(1);
    check("t4_clk_3", 32'(clk_out), 1);
    run(1);
    check("t4_clk_4", 32'(clk_out), 0);
    run(2);
    check("t4_clk_6", 32'(clk_out), 1);
    run(3);
    exp_q = '{32'd2, 32'd4, 32'd6, 32'd8};
    compare_ticks("t4_ticks");
    pulse_stop();

    // start+stop on the terminal count: stop wins, no tick
    load_div(18'd8);
    pulse_start();
    run(15);
    check("t5_clk_15", 32'(clk_out), 1);
    start = 1'b1;
    stop  = 1'b1;
    cyc_step();
    start = 1'b0;
    stop  = 1'b0;
    check("t5_kill_tick", 32'(tick), 0);
    check("t5_kill_busy", 32'(busy), 0);
    check("t5_kill_clk", 32'(clk_out), 0);
    check("t5_kill_state", 32'(dbg_state), 0);
    run(4);
    exp_q = '{32'd8};
    compare_ticks("t5_ticks");
    pulse_start();
    run(7);
    check("t5_restart_7", 32'(tick), 0);
    run(1);
    check("t5_restart_8", 32'(tick), 1);
`ifdef TICK_CNT_EN
    check("t5_tick_cnt", 32'(tick_cnt), 1);
`endif
    load_div(18'd5);
    check("t5_pend_ready", 32'(div_ready), 0);
    check("t5_pend_cur", 32'(cur_div), 8);
    pulse_stop();
    check("t5_stop_apply", 32'(cur_div), 5);
    check("t5_stop_ready", 32'(div_ready), 1);

    // asynchronous reset mid-run with a pending divisor
    load_div(18'd3);
    pulse_start();
    run(2);
    load_div(18'd2);
    check("t6_pre_tick", 32'(tick), 1);
    check("t6_pre_ready", 32'(div_ready), 0);
    reset = 1'b1;
    #2;
    check("t6_rst_tick", 32'(tick), 0);
    check("t6_rst_clk", 32'(clk_out), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ready", 32'(div_ready), 1);
    check("t6_rst_cur_div", 32'(cur_div), 5000);
`ifdef TICK_CNT_EN
    check("t6_rst_tick_cnt", 32'(tick_cnt), 0);
`endif
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    pulse_start();
    run(10000);
    exp_q = '{32'd5000, 32'd10000};
    compare_ticks("t6_ticks");
    check("t6_cur_div", 32'(cur_div), 5000);
    pulse_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
